seg_scan4: RTL

Four-digit multiplexed seven-segment driver that consumes the BCD digits produced by the seconds/minutes counter chain (mod60 stages) and drives a common-anode display. It scans one digit per refresh slot, snapshots all four digits once per frame so that a counter carry cannot tear the display, blanks leading zeros, and blinks the minutes/seconds separator from the counter's clock-enable pulse. It sits directly downstream of the counter chain, between the counters and the board pins.

---
 rtl/seg_scan4_if.sv | 24 ++
 rtl/seg_scan4.sv | 97 +++++++++
 2 files changed

// File: rtl/seg_scan4_if.sv
// rtl/seg_scan4_if.sv - counter-side digits/controls and display-side pins for seg_scan4
interface seg_scan4_if;
    logic       CE;
    logic       BLANK;
    logic [3:0] D0;
    logic [3:0] D1;
    logic [3:0] D2;
    logic [3:0] D3;
    logic [3:0] AN;
    logic [6:0] SEG;
    logic       DP;

    // Counter chain / stimulus side: supplies digits and controls, sees the pins
    modport master (
        output CE, BLANK, D0, D1, D2, D3,
        input  AN, SEG, DP
    );

    // Display driver side
    modport slave (
        input  CE, BLANK, D0, D1, D2, D3,
        output AN, SEG, DP
    );
endinterface

// File: rtl/seg_scan4.sv
// rtl/seg_scan4.sv - four-digit multiplexed common-anode seven-segment scanner
module seg_scan4 #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic         clk,
    input  logic         reset,
    seg_scan4_if.slave   bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0][3:0]   s_q, s_d;
    logic              blk_q, blk_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic              wrap;
    logic              blank3;
    logic              blank2;
    logic              cur_blank;
    logic [3:0]        cur_val;

    // Segment pattern {g,f,e,d,c,b,a}, active-low; non-BCD codes show a dash
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b0111111;
        endcase
        return p;
    endfunction

    // Slot timing, frame snapshot, blink flag and the registered pin values
    always_comb begin
        wrap    = (cnt_q == TC);
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
        blk_d   = blk_q ^ bus.CE;

        // Snapshot only at the frame boundary so a counter carry never tears the display
        s_d = s_q;
        if (wrap && (idx_q == 2'd3)) begin
            s_d[0] = bus.D0;
            s_d[1] = bus.D1;
            s_d[2] = bus.D2;
            s_d[3] = bus.D3;
        end

        // Leading-zero blanking only ever touches the two minutes digits
        blank3    = bus.BLANK && (s_q[3] == 4'd0);
        blank2    = bus.BLANK && (s_q[3] == 4'd0) && (s_q[2] == 4'd0);
        cur_val   = s_q[idx_q];
        cur_blank = ((idx_q == 2'd3) && blank3) || ((idx_q == 2'd2) && blank2);

        an_d  = cur_blank ? 4'b1111   : ~(4'b0001 << idx_q);
        seg_d = cur_blank ? 7'b1111111 : decode(cur_val);
        // Separator lives on digit 2 and follows the 1 Hz blink flag
        dp_d  = !((idx_q == 2'd2) && !blank2 && blk_q);
    end

    // State and output registers; reset returns to the power-on state with the display dark
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
            s_q   <= '0;
            blk_q <= 1'b0;
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            s_q   <= s_d;
            blk_q <= blk_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.AN  = an_q;
    assign bus.SEG = seg_q;
    assign bus.DP  = dp_q;
endmodule
